// File: rtl/student_coeff_loader.sv
// Coefficient RAM write-side sequencer.
// Takes a valid/ready stream of coefficients and writes N consecutive words
// from a base address through RAM port A. It can then read the block back
// through port B and compare the readback sum against the load sum.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start_i; parameters latched on start
// LOAD   | ready for stream words; each handshake writes one RAM word
// VERIFY | N reads on port B, then one drain cycle for the final read data
// DONE   | one-cycle done pulse; checksum_o already holds the load sum
module student_coeff_loader #(
    parameter int AddrWidth     = 10,
    parameter int CoeffDataSize = 16,
    parameter int ChecksumWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [AddrWidth-1:0]     base_addr_i,
    input  logic [AddrWidth:0]       num_coeff_i,
    input  logic                     verify_en_i,
    input  logic                     coeff_valid_i,
    input  logic [CoeffDataSize-1:0] coeff_data_i,
    output logic                     coeff_ready_o,
    output logic                     ram_ena_o,
    output logic                     ram_wea_o,
    output logic [AddrWidth-1:0]     ram_addra_o,
    output logic [CoeffDataSize-1:0] ram_dia_o,
    output logic                     ram_enb_o,
    output logic [AddrWidth-1:0]     ram_addrb_o,
    input  logic [CoeffDataSize-1:0] ram_dob_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [ChecksumWidth-1:0] checksum_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [AddrWidth:0] CntOne = {{AddrWidth{1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [AddrWidth-1:0]     base_q, base_d;
    logic [AddrWidth:0]       num_q, num_d;
    logic [AddrWidth:0]       idx_q, idx_d;
    logic                     verify_q, verify_d;
    logic [ChecksumWidth-1:0] load_sum_q, load_sum_d;
    logic [ChecksumWidth-1:0] rb_sum_q, rb_sum_d;
    logic [ChecksumWidth-1:0] checksum_q, checksum_d;
    logic                     error_q, error_d;
    logic                     rd_vld_q, rd_vld_d;

    // idx counts handshakes in LOAD and issued reads in VERIFY; the address
    // wraps naturally because the sum is truncated to AddrWidth bits.
    logic [AddrWidth-1:0] cur_addr;
    assign cur_addr = base_q + idx_q[AddrWidth-1:0];

    // State and datapath registers; reset leaves everything at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            verify_q   <= 1'b0;
            load_sum_q <= '0;
            rb_sum_q   <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            verify_q   <= verify_d;
            load_sum_q <= load_sum_d;
            rb_sum_q   <= rb_sum_d;
            checksum_q <= checksum_d;
            error_q    <= error_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    // Next-state logic plus the combinational RAM-port and stream outputs.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        num_d         = num_q;
        idx_d         = idx_q;
        verify_d      = verify_q;
        load_sum_d    = load_sum_q;
        rb_sum_d      = rb_sum_q;
        checksum_d    = checksum_q;
        error_d       = error_q;
        rd_vld_d      = 1'b0;
        coeff_ready_o = 1'b0;
        ram_ena_o     = 1'b0;
        ram_wea_o     = 1'b0;
        ram_addra_o   = '0;
        ram_dia_o     = '0;
        ram_enb_o     = 1'b0;
        ram_addrb_o   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    num_d      = num_coeff_i;
                    verify_d   = verify_en_i;
                    idx_d      = '0;
                    load_sum_d = '0;
                    rb_sum_d   = '0;
                    error_d    = 1'b0;
                    if (num_coeff_i == '0) begin
                        // Empty block: checksum of nothing is zero.
                        checksum_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                coeff_ready_o = 1'b1;
                if (coeff_valid_i) begin
                    ram_ena_o   = 1'b1;
                    ram_wea_o   = 1'b1;
                    ram_addra_o = cur_addr;
                    ram_dia_o   = coeff_data_i;
                    load_sum_d  = load_sum_q + ChecksumWidth'(coeff_data_i);
                    idx_d       = idx_q + CntOne;
                    if (idx_q == num_q - CntOne) begin
                        if (verify_q) begin
                            idx_d   = '0;
                            state_d = ST_VERIFY;
                        end else begin
                            checksum_d = load_sum_d;
                            state_d    = ST_DONE;
                        end
                    end
                end
            end

            ST_VERIFY: begin
                // Read data arrives one cycle after its enable.
                if (rd_vld_q) begin
                    rb_sum_d = rb_sum_q + ChecksumWidth'(ram_dob_i);
                end
                if (idx_q != num_q) begin
                    ram_enb_o   = 1'b1;
                    ram_addrb_o = cur_addr;
                    idx_d       = idx_q + CntOne;
                    rd_vld_d    = 1'b1;
                end else begin
                    // Drain cycle: the last read word has just been added.
                    error_d    = (rb_sum_d != load_sum_q);
                    checksum_d = load_sum_q;
                    state_d    = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign error_o    = error_q;
    assign checksum_o = checksum_q;

endmodule

// File: tb/tb_student_coeff_loader.sv
// Directed bench for the coefficient loader, using a 16-word RAM model so
// address wrap and full-depth loads stay short.
module tb_student_coeff_loader;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_coeff;
    logic          verify_en;
    logic          coeff_valid;
    logic [DW-1:0] coeff_data;
    logic          coeff_ready;
    logic          ram_ena, ram_wea, ram_enb;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dia, ram_dob;
    logic          busy, done, error;
    logic [CW-1:0] checksum;

    student_coeff_loader #(
        .AddrWidth(AW), .CoeffDataSize(DW), .ChecksumWidth(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .base_addr_i(base_addr), .num_coeff_i(num_coeff), .verify_en_i(verify_en),
        .coeff_valid_i(coeff_valid), .coeff_data_i(coeff_data), .coeff_ready_o(coeff_ready),
        .ram_ena_o(ram_ena), .ram_wea_o(ram_wea), .ram_addra_o(ram_addra), .ram_dia_o(ram_dia),
        .ram_enb_o(ram_enb), .ram_addrb_o(ram_addrb), .ram_dob_i(ram_dob),
        .busy_o(busy), .done_o(done), .error_o(error), .checksum_o(checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: synchronous write on port A, 1-cycle read on port B,
    // with an optional +1 corruption on reads of address 2.
    logic [DW-1:0] mem [0:15];
    logic          corrupt;
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= (corrupt && ram_addrb == 4'd2) ? mem[ram_addrb] + 16'd1 : mem[ram_addrb];
    end

    // Event log of RAM traffic, starts and done pulses.
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    int            wr_c [$];
    logic [AW-1:0] rd_a [$];
    int            cyc, done_c, done_cnt, start_c;
    always @(posedge clk) begin
        if (ram_ena && ram_wea) begin
            wr_a.push_back(ram_addra);
            wr_d.push_back(ram_dia);
            wr_c.push_back(cyc);
        end
        if (ram_enb) rd_a.push_back(ram_addrb);
        if (done) begin
            done_c = cyc;
            done_cnt++;
        end
        if (start && !busy) start_c = cyc;
        cyc++;
    end

    int checks, failures;
    logic [DW-1:0] data_v [0:15];
    logic err_after_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); wr_c.delete(); rd_a.delete();
        done_cnt = 0; done_c = -1; start_c = -1;
    endtask

    // Start one operation and stream data_v[0..n-1]; toggle alternates valid.
    task automatic run_op(input logic [AW-1:0] b, input logic [AW:0] n,
                          input logic ver, input bit toggle);
        int  k;
        int  budget;
        bit  vphase;
        bit  hs;
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_coeff = n; verify_en = ver;
        @(posedge clk); #1;
        start = 1'b0;
        err_after_start = error;
        k = 0; vphase = 1'b1; budget = 0;
        while (done_cnt == 0 && budget < 200) begin
            coeff_valid = (k < int'(n)) && (!toggle || vphase);
            coeff_data  = data_v[k % 16];
            @(negedge clk);
            hs = coeff_valid && coeff_ready;
            @(posedge clk); #1;
            if (hs) k++;
            vphase = !vphase;
            budget++;
        end
        coeff_valid = 1'b0;
        if (budget >= 200) chk("op_timeout", 32'(budget), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_coeff = '0; verify_en = 1'b0;
        coeff_valid = 1'b0; coeff_data = '0; corrupt = 1'b0;
        cyc = 0; clear_logs();
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            data_v[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(coeff_ready), 32'd0);
        chk("rst_ena", 32'(ram_ena), 32'd0);
        chk("rst_enb", 32'(ram_enb), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_csum", checksum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: base 0, N=4, verify, always valid
        data_v[0] = 16'd1; data_v[1] = 16'd2; data_v[2] = 16'd3; data_v[3] = 16'd4;
        run_op(4'd0, 5'd4, 1'b1, 1'b0);
        chk("t1_wr_count", 32'(wr_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr_addr", 32'(wr_a[i]), 32'(i));
            chk("t1_wr_data", 32'(wr_d[i]), 32'(i + 1));
        end
        chk("t1_wr_span", 32'(wr_c[3] - wr_c[0]), 32'd3);
        chk("t1_rd_count", 32'(rd_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_rd_addr", 32'(rd_a[i]), 32'(i));
        chk("t1_verify_len", 32'(done_c - wr_c[3]), 32'd6);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_csum", checksum, 32'd10);
        chk("t1_err", 32'(error), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // T2: valid toggling
        run_op(4'd0, 5'd4, 1'b1, 1'b1);
        chk("t2_wr_count", 32'(wr_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_wr_addr", 32'(wr_a[i]), 32'(i));
        chk("t2_wr_gap", 32'(wr_c[1] - wr_c[0]), 32'd2);
        chk("t2_csum", checksum, 32'd10);
        chk("t2_err", 32'(error), 32'd0);

        // T3: base 14 wraps to 0
        data_v[0] = 16'd5; data_v[1] = 16'd6; data_v[2] = 16'd7; data_v[3] = 16'd8;
        run_op(4'd14, 5'd4, 1'b1, 1'b0);
        chk("t3_wr_count", 32'(wr_a.size()), 32'd4);
        chk("t3_wr_a0", 32'(wr_a[0]), 32'd14);
        chk("t3_wr_a1", 32'(wr_a[1]), 32'd15);
        chk("t3_wr_a2", 32'(wr_a[2]), 32'd0);
        chk("t3_wr_a3", 32'(wr_a[3]), 32'd1);
        chk("t3_rd_a0", 32'(rd_a[0]), 32'd14);
        chk("t3_rd_a2", 32'(rd_a[2]), 32'd0);
        chk("t3_rd_a3", 32'(rd_a[3]), 32'd1);
        chk("t3_csum", checksum, 32'd26);
        chk("t3_err", 32'(error), 32'd0);

        // T4: corrupted readback of address 2
        data_v[0] = 16'd10; data_v[1] = 16'd20; data_v[2] = 16'd30; data_v[3] = 16'd40;
        corrupt = 1'b1;
        run_op(4'd0, 5'd4, 1'b1, 1'b0);
        corrupt = 1'b0;
        chk("t4_err", 32'(error), 32'd1);
        chk("t4_csum", checksum, 32'd100);

        // T4 continued / T5: N=0 start clears error, no RAM traffic
        run_op(4'd3, 5'd0, 1'b1, 1'b0);
        chk("t4_err_cleared", 32'(err_after_start), 32'd0);
        chk("t5_done_lat", 32'(done_c - start_c), 32'd1);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_wr_count", 32'(wr_a.size()), 32'd0);
        chk("t5_rd_count", 32'(rd_a.size()), 32'd0);
        chk("t5_csum", checksum, 32'd0);

        // Full depth: N=16 from base 5, every address exactly once
        for (int i = 0; i < 16; i++) data_v[i] = 16'(i + 1);
        run_op(4'd5, 5'd16, 1'b1, 1'b0);
        chk("full_wr_count", 32'(wr_a.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk("full_wr_addr", 32'(wr_a[i]), 32'((5 + i) % 16));
        chk("full_rd_count", 32'(rd_a.size()), 32'd16);
        chk("full_csum", checksum, 32'd136);
        chk("full_err", 32'(error), 32'd0);

        // No-verify path: done follows the last write directly
        data_v[0] = 16'h1234; data_v[1] = 16'hFFFF; data_v[2] = 16'h0001;
        run_op(4'd8, 5'd3, 1'b0, 1'b0);
        chk("nv_rd_count", 32'(rd_a.size()), 32'd0);
        chk("nv_done_lat", 32'(done_c - wr_c[2]), 32'd1);
        chk("nv_csum", checksum, 32'h11234);

        // T6: reset after 2 of 4 words
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd0; num_coeff = 5'd4; verify_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; coeff_valid = 1'b1; coeff_data = 16'h0011;
        @(posedge clk); #1;
        coeff_data = 16'h0022;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(coeff_ready), 32'd0);
        chk("t6_ena", 32'(ram_ena), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_csum", checksum, 32'd0);
        @(posedge clk); #1;
        chk("t6_wr_count", 32'(wr_a.size()), 32'd2);
        coeff_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        data_v[0] = 16'h0100; data_v[1] = 16'h0200;
        run_op(4'd0, 5'd2, 1'b1, 1'b0);
        chk("t6b_wr_count", 32'(wr_a.size()), 32'd2);
        chk("t6b_csum", checksum, 32'h300);
        chk("t6b_err", 32'(error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
